// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register slave: FSM encoding,
// register offsets and the saturating-counter helper.
package apb_slv_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;
  localparam int NUM_SCRATCH = 14;

  localparam logic [5:0] SCRATCH_BASE = 6'h00;
  localparam logic [5:0] WAIT_CFG_OFS = 6'h38;
  localparam logic [5:0] STATUS_OFS   = 6'h3C;

  localparam logic [3:0] NEVER_READY = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// Register storage, address decode and STATUS counters for apb_reg_slave.
// Decode is combinational for the response; updates happen only on commit.
module apb_slv_regfile
  import apb_slv_pkg::*;
#(
  parameter int         ADDR_W   = DEF_ADDR_W,
  parameter int         DATA_W   = DEF_DATA_W,
  parameter logic [3:0] DEF_WAIT = 4'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dec_addr_i,
  input  logic              dec_write_i,
  output logic              dec_err_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              commit_i,
  input  logic [ADDR_W-1:0] cm_addr_i,
  input  logic              cm_write_i,
  input  logic [DATA_W-1:0] cm_wdata_i,
  output logic [3:0]        wait_cfg_o
);

  logic [DATA_W-1:0] scratch_q [NUM_SCRATCH];
  logic [DATA_W-1:0] scratch_d [NUM_SCRATCH];
  logic [3:0]        wait_cfg_q, wait_cfg_d;
  logic [15:0]       good_cnt_q, good_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic wr);
    logic hi_nz;
    logic misaligned;
    logic ro_write;
    hi_nz      = |a[ADDR_W-1:6];
    misaligned = |a[1:0];
    ro_write   = wr && (a[5:0] == STATUS_OFS);
    return hi_nz | misaligned | ro_write;
  endfunction

  assign dec_err_o  = addr_err(dec_addr_i, dec_write_i);
  assign wait_cfg_o = wait_cfg_q;

  // Read mux for the address currently being decoded.
  always_comb begin
    rd_data_o = '0;
    if (dec_addr_i[5:0] == STATUS_OFS) begin
      rd_data_o[31:0] = {err_cnt_q, good_cnt_q};
    end else if (dec_addr_i[5:0] == WAIT_CFG_OFS) begin
      rd_data_o[3:0] = wait_cfg_q;
    end else begin
      rd_data_o = scratch_q[dec_addr_i[5:2]];
    end
  end

  // Next-state of storage and counters on a committed transfer.
  always_comb begin
    scratch_d  = scratch_q;
    wait_cfg_d = wait_cfg_q;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (commit_i) begin
      if (addr_err(cm_addr_i, cm_write_i)) begin
        err_cnt_d = sat_inc16(err_cnt_q);
      end else if (cm_write_i) begin
        good_cnt_d = sat_inc16(good_cnt_q);
        case (cm_addr_i[5:0])
          WAIT_CFG_OFS: wait_cfg_d = cm_wdata_i[3:0];
          default:      scratch_d[cm_addr_i[5:2]] = cm_wdata_i;
        endcase
      end else begin
        good_cnt_d = good_cnt_q;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q  <= '{default: '0};
      wait_cfg_q <= DEF_WAIT;
      good_cnt_q <= 16'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      scratch_q  <= scratch_d;
      wait_cfg_q <= wait_cfg_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB slave with programmable wait states: transfer FSM and registered
// PREADY/PSLVERR/PRDATA around the apb_slv_regfile storage.
module apb_reg_slave
  import apb_slv_pkg::*;
#(
  parameter logic [3:0] DEF_WAIT = 4'd2,
  parameter int         ADDR_W   = DEF_ADDR_W,
  parameter int         DATA_W   = DEF_DATA_W
) (
  input  logic              PCLK,
  input  logic              PRST,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              never_q, never_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic              commit_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic              cur_write_s;
  logic              dec_err_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [3:0]        wait_cfg_s;

  apb_slv_regfile #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEF_WAIT(DEF_WAIT)
  ) u_regfile (
    .clk        (PCLK),
    .rst        (PRST),
    .dec_addr_i (cur_addr_s),
    .dec_write_i(cur_write_s),
    .dec_err_o  (dec_err_s),
    .rd_data_o  (rd_data_s),
    .commit_i   (commit_s),
    .cm_addr_i  (addr_q),
    .cm_write_i (write_q),
    .cm_wdata_i (wdata_q),
    .wait_cfg_o (wait_cfg_s)
  );

  // In IDLE the transfer is not captured yet, so decode straight from the bus.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_addr_s  = PADDR;
      cur_write_s = PWRITE;
    end else begin
      cur_addr_s  = addr_q;
      cur_write_s = write_q;
    end
  end

  // Transfer FSM. The counter holds WAIT_CFG-1 so PREADY lands in access
  // cycle N+1; WAIT_CFG=0 goes straight to RESP from the setup phase.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    never_d  = never_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          never_d = (wait_cfg_s == NEVER_READY);
          if (wait_cfg_s == 4'd0) begin
            cnt_d   = 4'd0;
            state_d = ST_RESP;
          end else begin
            cnt_d   = wait_cfg_s - 4'd1;
            state_d = ST_SETUP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (never_q) begin
          state_d = ST_WAIT;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (PSEL && PENABLE) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response outputs are computed one cycle ahead and registered.
  always_comb begin
    pready_d  = (state_d == ST_RESP);
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (pready_d) begin
      pslverr_d = dec_err_s;
      if (!dec_err_s && !cur_write_s) begin
        prdata_d = rd_data_s;
      end else begin
        prdata_d = '0;
      end
    end else begin
      pslverr_d = 1'b0;
    end
  end

  // FSM, capture and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      never_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      never_q   <= never_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: the driver queues expected responses,
// an independent monitor checks each completed access against them.
module tb_apb_reg_slave;

  logic        PCLK    = 1'b0;
  logic        PRST    = 1'b1;
  logic        PSEL    = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [15:0] PADDR   = 16'h0000;
  logic [31:0] PWDATA  = 32'h0000_0000;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  apb_reg_slave #(.DEF_WAIT(4'd2), .ADDR_W(16), .DATA_W(32)) dut (
    .PCLK   (PCLK),
    .PRST   (PRST),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed access.
  initial begin
    exp_t e;
    int   acc_cnt;
    acc_cnt = 0;
    forever begin
      @(negedge PCLK);
      if (!PREADY) begin
        check("notready_prdata", PRDATA, 32'h0);
        check("notready_pslverr", {31'd0, PSLVERR}, 32'h0);
      end
      if (PSEL && !PENABLE) begin
        acc_cnt = 0;
      end else if (PSEL && PENABLE) begin
        acc_cnt = acc_cnt + 1;
        if (PREADY) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: got PREADY=1 expected no transfer pending");
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_rdata"}, PRDATA, e.rd);
            check({e.name, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, e.err});
            check({e.name, "_latency"}, 32'(acc_cnt), 32'(e.acc));
          end
        end
      end
    end
  end

  task automatic xfer(input string name, input logic wr, input logic [15:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_acc);
    exp_t e;
    int   waited;
    e.name = name;
    e.rd   = exp_rd;
    e.err  = exp_err;
    e.acc  = exp_acc;
    sb_q.push_back(e);
    @(posedge PCLK); #1;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = a;
    PWDATA  = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waited = 0;
    @(negedge PCLK);
    while (!PREADY && waited < 40) begin
      @(negedge PCLK);
      waited++;
    end
    if (!PREADY) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no PREADY after %0d cycles expected PREADY", name, waited);
      void'(sb_q.pop_back());
      PSEL    = 1'b0;
      PENABLE = 1'b0;
    end
  endtask

  task automatic bus_idle();
    @(posedge PCLK); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pready"}, {31'd0, PREADY}, 32'h0);
    check({tag, "_pslverr"}, {31'd0, PSLVERR}, 32'h0);
    check({tag, "_prdata"}, PRDATA, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge PCLK); #1;
    PRST    = 1'b1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRST = 1'b0;
    @(negedge PCLK);
    check_outputs_zero("reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Default two wait states: PREADY in access cycle 3.
    xfer("wr_scr0",   1'b1, 16'h0000, 32'hDEADBEEF, 32'h0,         1'b0, 3);
    xfer("rd_scr0",   1'b0, 16'h0000, 32'h0,        32'hDEADBEEF,  1'b0, 3);
    xfer("rd_status1",1'b0, 16'h003C, 32'h0,        32'h0000_0001, 1'b0, 3);
    xfer("wr_cfg0",   1'b1, 16'h0038, 32'h0,        32'h0,         1'b0, 3);

    // Zero wait states, back-to-back.
    xfer("wr_scr1",   1'b1, 16'h0004, 32'h12345678, 32'h0,         1'b0, 1);
    xfer("rd_scr1",   1'b0, 16'h0004, 32'h0,        32'h12345678,  1'b0, 1);

    // Decode errors.
    xfer("rd_oob",    1'b0, 16'h1000, 32'h0,        32'h0,         1'b1, 1);
    xfer("wr_status", 1'b1, 16'h003C, 32'hFFFFFFFF, 32'h0,         1'b1, 1);
    xfer("rd_status2",1'b0, 16'h003C, 32'h0,        32'h0002_0003, 1'b0, 1);
    xfer("rd_misal",  1'b0, 16'h0002, 32'h0,        32'h0,         1'b1, 1);

    // WAIT_CFG change applies from the next transfer; upper bits read 0.
    xfer("wr_cfg1",   1'b1, 16'h0038, 32'hFFFFFFF1, 32'h0,         1'b0, 1);
    xfer("rd_cfg1",   1'b0, 16'h0038, 32'h0,        32'h0000_0001, 1'b0, 2);
    xfer("rd_status3",1'b0, 16'h003C, 32'h0,        32'h0003_0004, 1'b0, 2);
    xfer("wr_scr13",  1'b1, 16'h0034, 32'h0BADF00D, 32'h0,         1'b0, 2);
    xfer("rd_scr13",  1'b0, 16'h0034, 32'h0,        32'h0BADF00D,  1'b0, 2);
    xfer("wr_cfgF",   1'b1, 16'h0038, 32'h0000000F, 32'h0,         1'b0, 2);
    bus_idle();

    // Never-ready: access held 15 cycles, then abandoned.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0008;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge PCLK);
      check("never_ready_pready", {31'd0, PREADY}, 32'h0);
    end
    bus_idle();
    @(negedge PCLK);
    check("abandon_pready", {31'd0, PREADY}, 32'h0);

    do_reset();
    xfer("rd_status_rst", 1'b0, 16'h003C, 32'h0, 32'h0, 1'b0, 3);
    bus_idle();

    // Reset during WAIT aborts the write.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h000C; PWDATA = 32'hA5A5A5A5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRST = 1'b1;
    @(posedge PCLK); #1;
    PRST = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check_outputs_zero("abort");
    xfer("rd_scr3_abort",    1'b0, 16'h000C, 32'h0, 32'h0, 1'b0, 3);
    xfer("rd_status_abort",  1'b0, 16'h003C, 32'h0, 32'h0, 1'b0, 3);
    bus_idle();

    repeat (2) @(posedge PCLK);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter DEF_WAIT, default 2: reset value of WAIT_CFG[3:0], the wait-state count.
REQ-002 Parameter ADDR_W, default 16: PADDR width.
REQ-003 Parameter DATA_W, default 32: PWDATA/PRDATA width.
REQ-004 PCLK  in  1  single clock; all logic on rising edge.
REQ-005 PRST  in  1  reset; synchronous, active-high.
REQ-006 PSEL  in  1  slave select from the APB master.
REQ-007 PENABLE  in  1  access phase indicator.
REQ-008 PWRITE  in  1  1=write, 0=read.
REQ-009 PADDR  in  ADDR_W  byte address.
REQ-010 PWDATA  in  DATA_W  write data.
REQ-011 PRDATA  out  DATA_W  read data; valid only while PREADY=1.
REQ-012 PREADY  out  1  transfer completion, registered.
REQ-013 PSLVERR  out  1  error response; valid only while PREADY=1.

Function
REQ-014 The register map SHALL be: 0x00-0x34 SCRATCH0-13 (RW, reset 0); 0x38 WAIT_CFG (RW, bits[3:0] used, others read 0); 0x3C STATUS (RO: [15:0] good-write count, [31:16] error count).
REQ-015 Decode SHALL error on any of: PADDR[ADDR_W-1:6]!=0, PADDR[1:0]!=0, or a write to 0x3C.
REQ-016 An errored transfer SHALL assert PSLVERR with PREADY, SHALL leave registers unchanged, and SHALL return PRDATA=0.
REQ-017 The FSM SHALL have states IDLE, SETUP, WAIT and RESP.
REQ-018 IDLE->SETUP on PSEL=1, PENABLE=0; the FSM SHALL capture PADDR, PWRITE, PWDATA and load the wait counter from WAIT_CFG[3:0].
REQ-019 SETUP->RESP when the counter is 0, else SETUP->WAIT.
REQ-020 WAIT SHALL decrement the counter each cycle and go to RESP when it reaches 0.
REQ-021 PREADY SHALL be 1 only in RESP, so it is high in access cycle N+1 for N wait states (N=0 gives zero-wait APB).
REQ-022 RESP->IDLE unconditionally; a write SHALL commit on the RESP edge (PSEL&PENABLE&PREADY).
REQ-023 WAIT_CFG=4'hF SHALL mean "never ready": the FSM stays in WAIT and PREADY stays 0, to exercise master timeout.
REQ-024 If PSEL=0 in SETUP, WAIT or RESP before completion, the FSM SHALL go to IDLE with no commit and no counter update (abandoned transfer).
REQ-025 Back-to-back transfers SHALL be supported: a new setup in the cycle after RESP is accepted from IDLE with no bubble beyond the APB setup phase.
REQ-026 STATUS counters SHALL saturate at 16'hFFFF and never wrap; a good write increments [15:0], an errored read or write increments [31:16].
REQ-027 A WAIT_CFG write SHALL take effect from the next transfer, never the current one.
REQ-028 PRDATA and PSLVERR SHALL be driven 0 whenever PREADY=0.

Reset
REQ-029 On PRST=1 at a PCLK edge: FSM=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, SCRATCH=0, WAIT_CFG=DEF_WAIT, STATUS=0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no commit; PREADY=0 on the following cycle.

Structure
REQ-031 Package apb_slv_pkg SHALL hold the FSM state encoding, register offsets (SCRATCH_BASE, WAIT_CFG_OFS=0x38, STATUS_OFS=0x3C), the NEVER_READY=4'hF constant, and default widths.
REQ-032 Sub-module apb_slv_regfile SHALL hold the storage, decode and saturating counters; apb_reg_slave holds the FSM and the output registers.

Verification
REQ-033 Reset, then write 0x00=0xDEADBEEF and read 0x00 with DEF_WAIT=2 -> PREADY high in access cycle 3 each time; read data 0xDEADBEEF; STATUS=0x0000_0001.
REQ-034 Write WAIT_CFG=0, then back-to-back write/read to 0x04=0x12345678 -> PREADY in the first access cycle; data 0x12345678; no idle bubble.
REQ-035 Read 0x1000 and write 0x3C -> PSLVERR=1 with PREADY, PRDATA=0, STATUS[31:16]=2, 0x3C unchanged.
REQ-036 WAIT_CFG=0xF, read 0x08 held 15 cycles, then PSEL dropped -> PREADY stays 0 throughout; FSM returns to IDLE; next transfer (after WAIT_CFG restored via fresh reset) completes normally.
REQ-037 Write 0x0C=0xA5A5A5A5 with PRST pulsed during WAIT -> no commit; 0x0C reads 0; outputs 0 the cycle after reset.
